// File: rtl/dphy_ctrl_pkg.sv
// Shared types and constants for the D-PHY receive lane sequencer.
//   state_t : 3-bit lane FSM encoding. This is also the value driven on dbg_state.
//   LP11/LP10/LP01/LP00 : single-ended LP line codes, ordered {Dp, Dn}.
package dphy_ctrl_pkg;

  typedef enum logic [2:0] {
    INIT      = 3'd0,
    STOP      = 3'd1,
    HS_RQST   = 3'd2,
    SETTLE    = 3'd3,
    HS_RX     = 3'd4,
    WAIT_STOP = 3'd5,
    ESC       = 3'd6
  } state_t;

  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP10 = 2'b10;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

endpackage

// File: rtl/dphy_lp_filter.sv
// LP line front end: 2-flop synchronizer plus a run-length glitch filter.
// Ports:
//   clk, areset : dphy_clk and asynchronous active-high reset.
//   lp_p, lp_n  : asynchronous LP receiver outputs (Dp, Dn).
//   acc         : accepted LP code {Dp, Dn}. It resets to LP00.
// A code becomes accepted once LP_FILT consecutive synchronized samples agree.
// The pin-to-acc latency is therefore 2 + LP_FILT cycles.
module dphy_lp_filter
  import dphy_ctrl_pkg::*;
#(
  parameter int LP_FILT = 4
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       lp_p,
  input  logic       lp_n,
  output logic [1:0] acc
);

  localparam logic [3:0] FILT = 4'(LP_FILT);

  logic [1:0] sync1;
  logic [1:0] code;
  logic [1:0] last;
  logic [3:0] cnt;
  logic [3:0] cnt_n;

  // Run length of the current synchronized code, including this sample.
  // The count saturates at FILT, so a held code keeps acc stable.
  always_comb begin
    cnt_n = cnt;
    if (code != last) begin
      cnt_n = 4'd1;
    end else if (cnt != FILT) begin
      cnt_n = cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      sync1 <= LP00;
      code  <= LP00;
      last  <= LP00;
      cnt   <= 4'd0;
      acc   <= LP00;
    end else begin
      sync1 <= {lp_p, lp_n};
      code  <= sync1;
      last  <= code;
      cnt   <= cnt_n;
      if (cnt_n == FILT) begin
        acc <= code;
      end
    end
  end

endmodule

// File: rtl/dphy_rx_lane_ctrl.sv
// D-PHY receive lane sequencer. It walks LP-11 -> LP-01 -> LP-00 into an HS burst,
// drives HS termination, and holds the datapath in reset outside bursts.
// It also flags a missing sync byte and illegal LP transitions.
// Ports:
//   dphy_clk, areset : continuous HS clock; asynchronous active-high reset.
//   lp_p, lp_n       : asynchronous LP receiver levels.
//   cfg_settle       : HS settle length. It is captured on SETTLE entry.
//   sync_seen        : aligner found the sync byte. This is a level input.
//   term_en          : HS termination enable (SETTLE or HS_RX).
//   dp_reset         : datapath reset, low only in HS_RX.
//   wait_sync        : in HS_RX and still hunting for the sync byte.
//   hs_active        : lane in HS_RX.
//   burst_end        : 1-cycle pulse on HS_RX -> STOP.
//   err_sot          : 1-cycle pulse when the sync timeout fires.
//   err_ctrl         : 1-cycle pulse on an illegal LP transition.
//   burst_count      : number of HS_RX entries. It wraps.
//   dbg_state        : current FSM state encoding.
// All outputs are registered from the next-state values, so they change on the same edge as the state.
module dphy_rx_lane_ctrl
  import dphy_ctrl_pkg::*;
#(
  parameter int LP_FILT     = 4,
  parameter int INIT_CYCLES = 64,
  parameter int SYNC_TO     = 32
) (
  input  logic        dphy_clk,
  input  logic        areset,
  input  logic        lp_p,
  input  logic        lp_n,
  input  logic [7:0]  cfg_settle,
  input  logic        sync_seen,
  output logic        term_en,
  output logic        dp_reset,
  output logic        wait_sync,
  output logic        hs_active,
  output logic        burst_end,
  output logic        err_sot,
  output logic        err_ctrl,
  output logic [15:0] burst_count,
  output logic [2:0]  dbg_state
);

  localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);
  localparam logic [7:0]  SYNC_LAST = 8'(SYNC_TO - 1);

  logic [1:0]  acc;
  state_t      state;
  state_t      state_n;
  logic [15:0] init_cnt;
  logic [15:0] init_cnt_n;
  logic [7:0]  settle_cnt;
  logic [7:0]  settle_cnt_n;
  logic [7:0]  sync_tmr;
  logic [7:0]  sync_tmr_n;
  logic        sync_found;
  logic        sync_found_n;
  logic        burst_end_n;
  logic        err_sot_n;
  logic        err_ctrl_n;
  logic        burst_inc;

  dphy_lp_filter #(.LP_FILT(LP_FILT)) u_lp_filter (
    .clk    (dphy_clk),
    .areset (areset),
    .lp_p   (lp_p),
    .lp_n   (lp_n),
    .acc    (acc)
  );

  always_comb begin
    state_n      = state;
    init_cnt_n   = 16'd0;  // the counter only accumulates while in INIT
    settle_cnt_n = settle_cnt;
    sync_tmr_n   = sync_tmr;
    sync_found_n = sync_found;
    burst_end_n  = 1'b0;
    err_sot_n    = 1'b0;
    err_ctrl_n   = 1'b0;
    case (state)
      INIT: begin
        if (acc == LP11) begin
          if (init_cnt == INIT_LAST) state_n = STOP;
          else init_cnt_n = init_cnt + 16'd1;
        end
      end
      STOP: begin
        case (acc)
          LP01: state_n = HS_RQST;
          LP10: state_n = ESC;
          LP00: begin
            state_n    = INIT;
            err_ctrl_n = 1'b1;
          end
          default: ;
        endcase
      end
      HS_RQST: begin
        case (acc)
          LP00: begin
            state_n      = SETTLE;
            settle_cnt_n = cfg_settle;
          end
          LP11: state_n = STOP;
          LP10: begin
            state_n    = INIT;
            err_ctrl_n = 1'b1;
          end
          default: ;
        endcase
      end
      SETTLE: begin
        // A return to LP-11 aborts the request even on the expiry cycle.
        if (acc == LP11) begin
          state_n = STOP;
        end else if (settle_cnt == 8'd0) begin
          state_n      = HS_RX;
          sync_tmr_n   = 8'd0;
          sync_found_n = 1'b0;
        end else begin
          settle_cnt_n = settle_cnt - 8'd1;
        end
      end
      HS_RX: begin
        // Priority order: end of burst, then sync found, then timeout.
        if (acc == LP11) begin
          state_n     = STOP;
          burst_end_n = 1'b1;
        end else if (!sync_found) begin
          if (sync_seen) begin
            sync_found_n = 1'b1;
          end else if (sync_tmr == SYNC_LAST) begin
            state_n   = WAIT_STOP;
            err_sot_n = 1'b1;
          end else begin
            sync_tmr_n = sync_tmr + 8'd1;
          end
        end
      end
      WAIT_STOP, ESC: begin
        if (acc == LP11) state_n = STOP;
      end
      default: state_n = INIT;
    endcase
  end

  assign burst_inc = (state == SETTLE) && (state_n == HS_RX);

  always_ff @(posedge dphy_clk or posedge areset) begin
    if (areset) begin
      state       <= INIT;
      init_cnt    <= 16'd0;
      settle_cnt  <= 8'd0;
      sync_tmr    <= 8'd0;
      sync_found  <= 1'b0;
      term_en     <= 1'b0;
      dp_reset    <= 1'b1;
      wait_sync   <= 1'b0;
      hs_active   <= 1'b0;
      burst_end   <= 1'b0;
      err_sot     <= 1'b0;
      err_ctrl    <= 1'b0;
      burst_count <= 16'd0;
      dbg_state   <= 3'd0;
    end else begin
      state       <= state_n;
      init_cnt    <= init_cnt_n;
      settle_cnt  <= settle_cnt_n;
      sync_tmr    <= sync_tmr_n;
      sync_found  <= sync_found_n;
      term_en     <= (state_n == SETTLE) || (state_n == HS_RX);
      dp_reset    <= (state_n != HS_RX);
      hs_active   <= (state_n == HS_RX);
      wait_sync   <= (state_n == HS_RX) && !sync_found_n;
      burst_end   <= burst_end_n;
      err_sot     <= err_sot_n;
      err_ctrl    <= err_ctrl_n;
      dbg_state   <= 3'(state_n);
      if (burst_inc) burst_count <= burst_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dphy_rx_lane_ctrl.sv
// Directed testbench for dphy_rx_lane_ctrl with default parameters.
// Stimulus pushes the expected output events, each with its cycle distance from the previous event.
// The monitor pops an entry and compares whenever the outputs change or a pulse fires.
module tb_dphy_rx_lane_ctrl;
  import dphy_ctrl_pkg::*;

  logic        dphy_clk = 1'b0;
  logic        areset   = 1'b1;
  logic        lp_p     = 1'b1;
  logic        lp_n     = 1'b1;
  logic [7:0]  cfg_settle = 8'd10;
  logic        sync_seen  = 1'b0;
  logic        term_en, dp_reset, wait_sync, hs_active;
  logic        burst_end, err_sot, err_ctrl;
  logic [15:0] burst_count;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc = 0;

  // Event record: {wait_sync, term_en, dp_reset, hs_active, burst_end, err_sot, err_ctrl, state}
  logic [9:0] exp_q[$];
  int         dt_q[$];   // expected cycles since the previous event, -1 = not checked

  dphy_rx_lane_ctrl dut (
    .dphy_clk    (dphy_clk),
    .areset      (areset),
    .lp_p        (lp_p),
    .lp_n        (lp_n),
    .cfg_settle  (cfg_settle),
    .sync_seen   (sync_seen),
    .term_en     (term_en),
    .dp_reset    (dp_reset),
    .wait_sync   (wait_sync),
    .hs_active   (hs_active),
    .burst_end   (burst_end),
    .err_sot     (err_sot),
    .err_ctrl    (err_ctrl),
    .burst_count (burst_count),
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 dphy_clk = ~dphy_clk;
  always @(posedge dphy_clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [9:0] ev(state_t st, logic ws, logic be, logic es, logic ec);
    logic hs, te, dp;
    hs = (st == HS_RX);
    te = (st == SETTLE) || hs;
    dp = !hs;
    return {ws, te, dp, hs, be, es, ec, 3'(st)};
  endfunction

  // driver tasks
  task automatic push(input logic [9:0] rec, input int dt);
    exp_q.push_back(rec);
    dt_q.push_back(dt);
  endtask

  task automatic hold(input logic [1:0] lp, input int n);
    {lp_p, lp_n} = lp;
    repeat (n) @(posedge dphy_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_term_en"},     16'(term_en),   16'd0);
    chk({tag, "_dp_reset"},    16'(dp_reset),  16'd1);
    chk({tag, "_wait_sync"},   16'(wait_sync), 16'd0);
    chk({tag, "_hs_active"},   16'(hs_active), 16'd0);
    chk({tag, "_burst_end"},   16'(burst_end), 16'd0);
    chk({tag, "_err_sot"},     16'(err_sot),   16'd0);
    chk({tag, "_err_ctrl"},    16'(err_ctrl),  16'd0);
    chk({tag, "_burst_count"}, burst_count,    16'd0);
    chk({tag, "_dbg_state"},   16'(dbg_state), 16'd0);
  endtask

  // Burst with sync found 6 cycles after HS_RX entry (cfg_settle = 10), then LP-11.
  task automatic normal_burst(input int dt_first);
    push(ev(HS_RQST, 0, 0, 0, 0), dt_first);
    push(ev(SETTLE,  0, 0, 0, 0), 10);
    push(ev(HS_RX,   1, 0, 0, 0), 11);
    push(ev(HS_RX,   0, 0, 0, 0), 6);
    push(ev(STOP,    0, 1, 0, 0), 23);
    hold(LP01, 10);
    hold(LP00, 23);
    sync_seen = 1'b1;
    hold(LP00, 4);
    sync_seen = 1'b0;
    hold(LP00, 13);
    hold(LP11, 20);
  endtask

  // scoreboard monitor
  logic [9:0] mon_cur;
  logic [9:0] mon_exp;
  int         mon_dt;
  logic [6:0] prev_np = 7'b0010000;  // reset values of the non-pulse fields

  always @(negedge dphy_clk) begin
    mon_cur = {wait_sync, term_en, dp_reset, hs_active, burst_end, err_sot, err_ctrl, dbg_state};
    if (({mon_cur[9:6], mon_cur[2:0]} !== prev_np) || (mon_cur[5:3] != 3'b000)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got %b at cycle %0d, required no event", mon_cur, cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        mon_dt  = dt_q.pop_front();
        if (mon_cur !== mon_exp) begin
          errors++;
          $display("FAIL event_flags: got %b, required %b (cycle %0d)", mon_cur, mon_exp, cyc);
        end
        if (mon_dt >= 0) begin
          checks++;
          if (cyc - last_cyc != mon_dt) begin
            errors++;
            $display("FAIL event_delay: got %0d, required %0d (cycle %0d)", cyc - last_cyc, mon_dt, cyc);
          end
        end
      end
      last_cyc = cyc;
    end
    prev_np = {mon_cur[9:6], mon_cur[2:0]};
  end

  initial begin
    repeat (3) @(posedge dphy_clk);
    #1;
    chk_reset_outputs("reset");
    areset = 1'b0;

    // Start-of-transmission: INIT -> STOP after 64 cycles of accepted LP-11,
    // then a burst with no sync byte, which times out into WAIT_STOP.
    push(ev(STOP,      0, 0, 0, 0), 73);
    push(ev(HS_RQST,   0, 0, 0, 0), 37);
    push(ev(SETTLE,    0, 0, 0, 0), 20);
    push(ev(HS_RX,     1, 0, 0, 0), 11);
    push(ev(WAIT_STOP, 0, 0, 1, 0), 32);
    push(ev(STOP,      0, 0, 0, 0), 17);
    hold(LP11, 100);
    hold(LP01, 20);
    hold(LP00, 60);
    chk("burst_count_1", burst_count, 16'd1);
    hold(LP11, 20);

    // Normal burst with sync found.
    normal_burst(20);
    chk("burst_count_2", burst_count, 16'd2);
    chk("term_en_after_burst", 16'(term_en), 16'd0);

    // Glitch rejection: 3 cycles of LP-01 are ignored; 4 cycles are accepted.
    push(ev(HS_RQST, 0, 0, 0, 0), 33);
    push(ev(STOP,    0, 0, 0, 0), 4);
    hold(LP01, 3);
    hold(LP11, 10);
    hold(LP01, 4);
    hold(LP11, 16);

    // Illegal STOP -> LP-00 sends the lane to INIT; recovery needs 64 LP-11 cycles.
    // STOP -> LP-10 is an escape entry and raises no error.
    push(ev(INIT, 0, 0, 0, 1), 16);
    push(ev(STOP, 0, 0, 0, 0), 73);
    push(ev(ESC,  0, 0, 0, 0), 27);
    push(ev(STOP, 0, 0, 0, 0), 10);
    hold(LP00, 10);
    hold(LP11, 90);
    hold(LP10, 10);
    hold(LP11, 20);

    // LP-11 accepted on the sync-timeout cycle: burst_end fires and err_sot does not.
    push(ev(HS_RQST, 0, 0, 0, 0), 20);
    push(ev(SETTLE,  0, 0, 0, 0), 10);
    push(ev(HS_RX,   1, 0, 0, 0), 11);
    push(ev(STOP,    0, 1, 0, 0), 32);
    hold(LP01, 10);
    hold(LP00, 43);
    hold(LP11, 20);

    // sync_seen arriving on the timeout cycle suppresses err_sot.
    push(ev(HS_RQST, 0, 0, 0, 0), 20);
    push(ev(SETTLE,  0, 0, 0, 0), 10);
    push(ev(HS_RX,   1, 0, 0, 0), 11);
    push(ev(HS_RX,   0, 0, 0, 0), 32);
    push(ev(STOP,    0, 1, 0, 0), 17);
    hold(LP01, 10);
    hold(LP00, 49);
    sync_seen = 1'b1;
    hold(LP00, 4);
    sync_seen = 1'b0;
    hold(LP00, 7);
    hold(LP11, 20);
    chk("burst_count_4", burst_count, 16'd4);

    // areset asserted mid-HS_RX returns every output to its reset value.
    push(ev(HS_RQST, 0, 0, 0, 0), 20);
    push(ev(SETTLE,  0, 0, 0, 0), 10);
    push(ev(HS_RX,   1, 0, 0, 0), 11);
    push(ev(INIT,    0, 0, 0, 0), -1);
    push(ev(STOP,    0, 0, 0, 0), 73);
    hold(LP01, 10);
    hold(LP00, 25);
    #2;
    areset = 1'b1;
    {lp_p, lp_n} = LP11;
    #1;
    chk_reset_outputs("midburst_reset");
    repeat (3) @(posedge dphy_clk);
    #1;
    areset = 1'b0;
    hold(LP11, 90);

    // burst_count wraps 0xFFFF -> 0.
    force dut.burst_count = 16'hFFFE;
    #1;
    release dut.burst_count;
    normal_burst(27);
    chk("burst_count_ffff", burst_count, 16'hFFFF);
    normal_burst(20);
    chk("burst_count_wrap", burst_count, 16'h0000);

    hold(LP11, 10);
    chk("events_left", 16'(exp_q.size()), 16'd0);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dphy_rx_lane_ctrl.md
# dphy_rx_lane_ctrl

D-PHY receive-side lane sequencer for the CSI-2 receiver. It runs on the continuous HS clock (dphy_clk), monitors the single-ended LP levels of the data lanes and walks the LP-11 → LP-01 → LP-00 start-of-transmission sequence. It controls HS termination enable, holds the byte aligner / word combiner in reset outside bursts, and flags missing sync words and illegal LP sequences. It replaces the free-running counter reset currently used to release the datapath.

## Interface
Parameters:
- LP_FILT, 4: consecutive identical synchronized LP samples required to accept a new LP code (1..15).
- INIT_CYCLES, 64: cycles of accepted LP-11 required after reset before leaving INIT (1..65535).
- SYNC_TO, 32: cycles in HS_RX without sync_seen before err_sot (1..255).

Ports:
- dphy_clk, in, 1: HS bit clock, continuous; all logic on rising edge.
- areset, in, 1: asynchronous, active-high reset.
- lp_p, in, 1: LP receiver, Dp; asynchronous.
- lp_n, in, 1: LP receiver, Dn; asynchronous.
- cfg_settle, in, 8: HS settle length in dphy_clk cycles; quasi-static, sampled on SETTLE entry.
- sync_seen, in, 1: aligner found sync byte; level held ≥4 dphy_clk cycles (word_clk domain, dphy_clk-derived).
- term_en, out, 1: HS termination / LVDS input enable.
- dp_reset, out, 1: synchronous reset to aligner, combiner and packet handler.
- wait_sync, out, 1: datapath hunting for sync byte.
- hs_active, out, 1: lane in HS_RX.
- burst_end, out, 1: one-cycle pulse on HS_RX → STOP.
- err_sot, out, 1: one-cycle pulse, sync timeout.
- err_ctrl, out, 1: one-cycle pulse, illegal LP transition.
- burst_count, out, 16: HS bursts entered, wraps 0xFFFF → 0.
- dbg_state, out, 3: current state encoding.

## Operation
- LP front end: 2-flop synchronizer on {lp_p, lp_n} → code. Filter counter counts consecutive equal code samples; accepted code (acc) updates when the count reaches LP_FILT. Reset value of acc: 2'b00.
- States: INIT, STOP, HS_RQST, SETTLE, HS_RX, WAIT_STOP, ESC.
- INIT: counter clears whenever acc≠11; when acc=11 has been held INIT_CYCLES cycles → STOP.
- STOP: acc 01 → HS_RQST; acc 10 → ESC; acc 00 → err_ctrl pulse, INIT.
- HS_RQST: acc 00 → SETTLE, load settle counter with cfg_settle; acc 11 → STOP; acc 10 → err_ctrl, INIT.
- SETTLE: decrement counter; at 0 → HS_RX, so cfg_settle=0 gives 1 cycle and N gives N+1 cycles. acc 11 → STOP with precedence over counter expiry.
- HS_RX: on entry wait_sync=1, burst_count+1, sync timer cleared. sync_seen clears wait_sync and stops timer. Timer reaching SYNC_TO with wait_sync=1 → err_sot, WAIT_STOP. acc 11 → STOP with burst_end.
- WAIT_STOP / ESC: hold until acc 11 → STOP. No burst_end pulse.
- Decodes: term_en = SETTLE|HS_RX. dp_reset = !HS_RX. hs_active = HS_RX. wait_sync = HS_RX & !sync_found.
- Precedence in HS_RX for the same cycle: acc 11 beats timeout (burst_end, no err_sot). sync_seen beats timeout (no err_sot).
- Reset values: state INIT, term_en 0, dp_reset 1, wait_sync 0, hs_active 0, pulses 0, burst_count 0, dbg_state 0.
- Reset asserted mid-burst: immediate return to INIT values. No burst_end is generated.

## Timing
- All outputs are registered and change on the same edge as state.
- Pin change to acc: 2 sync cycles + LP_FILT cycles.
- acc change to state and outputs: 1 cycle.
- Pulses are exactly 1 cycle wide. burst_count updates on the HS_RX entry edge.
- dp_reset deasserts on the same edge hs_active rises, and reasserts on the same edge it falls.

## Structure
- Package dphy_ctrl_pkg contains:
  - state enum, 3-bit: INIT=0, STOP=1, HS_RQST=2, SETTLE=3, HS_RX=4, WAIT_STOP=5, ESC=6;
  - LP code constants LP11, LP10, LP01, LP00.
- Sub-module dphy_lp_filter contains the synchronizer and glitch filter. Parameter: LP_FILT. Ports: clk, areset, lp_p, lp_n → acc[1:0].
- The top level contains the FSM, counters and decodes.

## Test plan
- Start-of-transmission with defaults: hold 11 for 100 cycles, then 01 ×20, 00 with cfg_settle=10.
  - Required: STOP reached; term_en rises 1 cycle after acc=00; hs_active rises 11 cycles later; burst_count=1.
- Sync timeout: no sync_seen for 32 cycles in HS_RX.
  - Required: err_sot is a single pulse; state is WAIT_STOP; dp_reset=1; drive 11 → STOP with no burst_end.
- Normal burst: sync_seen 5 cycles after HS_RX entry, then 11.
  - Required: wait_sync falls; burst_end pulses once; term_en=0.
- Glitch rejection: 3-cycle 01 glitch in STOP (LP_FILT=4).
  - Required: no state change. 4-cycle 01 → HS_RQST.
- Illegal sequences:
  - STOP → 00 gives err_ctrl, then INIT. Recovery needs 64 cycles of 11.
  - STOP → 10 gives ESC and no error.
- Simultaneous and reset cases:
  - acc 11 on the timeout cycle gives burst_end and no err_sot.
  - areset mid-HS_RX returns all outputs to reset values.
  - burst_count wraps from 0xFFFF to 0.
